// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter with a single-word status/command register.
// Optional watchdog between device clock edges is enabled by PS2_TX_TIMEOUT_EN.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 1200,
  parameter int START_CYCLES   = 16,
  parameter int LEN            = 8,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait,
  output logic        tx_busy
);

  typedef enum logic [2:0] {IDLE, INHIBIT, START, XFER, ACK, RECOVER} state_t;

  localparam int CNT_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             nack_q, nack_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic [LEN:0]     hist_q, hist_d;
  logic             deb_q, deb_d;
  logic             fall_q, fall_d;
  logic             unused_bits;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_hit;
  assign to_hit      = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
  assign unused_bits = ^reg_dat_di[31:8];
`else
  assign unused_bits = ^{reg_dat_di[31:8], (TIMEOUT_CYCLES != 0)};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    nack_d      = nack_q;
    timeout_d   = timeout_q;
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    hist_d      = {hist_q[LEN-1:0], clk_sync_q[1]};
    // Debounced level only moves once the whole history agrees.
    deb_d       = (&hist_q) ? 1'b1 : ((~|hist_q) ? 1'b0 : deb_q);
    fall_d      = deb_q & ~deb_d;

    if (reg_dat_re) begin
      nack_d    = 1'b0;
      timeout_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (reg_dat_we) begin
          shift_d   = reg_dat_di[7:0];
          parity_d  = ~^reg_dat_di[7:0];
          nack_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          clk_oe_d  = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          bitcnt_d = 4'd0;
          state_d  = XFER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER: begin
        if (fall_q) begin
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q < 4'd8) begin
            data_oe_d = ~shift_q[bitcnt_q[2:0]];
          end else if (bitcnt_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        if (fall_q) begin
          bitcnt_d = 4'd11;
          if (data_sync_q[1]) nack_d = 1'b1;
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (deb_q && data_sync_q[1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog runs only while the device owns the clock; it is zero elsewhere.
    to_cnt_d = '0;
    if (state_q == XFER || state_q == ACK || state_q == RECOVER) begin
      if (fall_q)       to_cnt_d = '0;
      else if (!to_hit) to_cnt_d = to_cnt_q + 1'b1;
      else              to_cnt_d = to_cnt_q;
      if (to_hit) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        timeout_d = 1'b1;
        state_d   = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= 4'd0;
      shift_q     <= 8'd0;
      parity_q    <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      nack_q      <= 1'b0;
      timeout_q   <= 1'b0;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      hist_q      <= '1;
      deb_q       <= 1'b1;
      fall_q      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      nack_q      <= nack_d;
      timeout_q   <= timeout_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      hist_q      <= hist_d;
      deb_q       <= deb_d;
      fall_q      <= fall_d;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign tx_busy      = (state_q != IDLE);
  assign reg_dat_wait = reg_dat_we && (state_q != IDLE);
  assign reg_dat_do   = {29'd0, timeout_q, nack_q, tx_busy};

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: open-drain bus, behavioural PS/2 device and
// frame/status reference model; honours PS2_TX_TIMEOUT_EN when defined.
module tb_ps2_tx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ps2_clk, ps2_data;
  logic        ps2_clk_oe, ps2_data_oe;
  logic        reg_dat_we = 1'b0;
  logic        reg_dat_re = 1'b0;
  logic [31:0] reg_dat_di = 32'd0;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;
  logic        tx_busy;
  logic        dev_clk_low = 1'b0;
  logic        dev_data_low = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  ps2_tx dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
    .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no finish, expected finish before 95000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference frame as the device sees it: 8 data bits LSB first, odd parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // Write a byte, then measure the inhibit and start phases driven by the host.
  task automatic applyStimulus(input logic [7:0] b, input bit expect_stall);
    int n;
    @(negedge clk);
    reg_dat_we = 1'b1;
    reg_dat_di = {$urandom, b} >> 0;
    reg_dat_di[7:0] = b;
    #1;
    checkOutput(expect_stall ? "wait_stall" : "wait_free", {31'd0, reg_dat_wait}, {31'd0, expect_stall});
    n = 0;
    while (reg_dat_wait && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_bound", {31'd0, reg_dat_wait}, 32'd0);
    @(negedge clk);
    reg_dat_we = 1'b0;
    checkOutput("latency_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
    checkOutput("busy_set", {31'd0, tx_busy}, 32'd1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 3000) begin
      n++;
      @(negedge clk);
    end
    checkOutput("inhibit_len", n, 32'd1200);
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("start_len", n, 32'd16);
  endtask

  // Device model: generates n_falls clocks, samples data before each rising edge.
  task automatic run_device(input int n_falls, input bit ack, input int h, output logic [10:0] bits);
    bits = '0;
    checkOutput("start_bit", {31'd0, ps2_data}, 32'd0);
    for (int i = 1; i <= n_falls; i++) begin
      repeat (h) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (h) @(negedge clk);
      bits[i-1] = ps2_data;
      if (i == 10 && ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b0;
      if (i == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tx_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    @(negedge clk);
    checkOutput(tag, reg_dat_do, exp);
    reg_dat_re = 1'b1;
    @(negedge clk);
    reg_dat_re = 1'b0;
  endtask

  task automatic full_transfer(input logic [7:0] b, input bit ack, input string tag);
    logic [10:0] bits;
    int h = $urandom_range(30, 45);
    applyStimulus(b, 1'b0);
    run_device(11, ack, h, bits);
    checkOutput(tag, {22'd0, bits[9:0]}, {22'd0, frame_of(b)});
    wait_idle({tag, "_idle"});
    @(negedge clk);
    checkOutput({tag, "_status"}, reg_dat_do, ack ? 32'd0 : 32'd2);
  endtask

  initial begin
    logic [10:0] bits1, bits2;
    logic [7:0]  rb;
    int          h;

    repeat (3) @(negedge clk);
    checkOutput("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    checkOutput("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    checkOutput("rst_status", reg_dat_do, 32'd0);
    checkOutput("rst_wait", {31'd0, reg_dat_wait}, 32'd0);
    resetn = 1'b1;
    repeat (20) @(negedge clk);

    full_transfer(8'hED, 1'b1, "frame_ED");

    full_transfer(8'hFF, 1'b0, "frame_FF");
    read_status("nack_read1", 32'd2);
    read_status("nack_read2", 32'd0);

    full_transfer(8'h00, 1'b1, "frame_00");

    rb = 8'($urandom);
    h = $urandom_range(30, 45);
    applyStimulus(rb, 1'b0);
    fork
      run_device(11, 1'b1, h, bits1);
      begin
        repeat (300) @(negedge clk);
        applyStimulus(8'hF4, 1'b1);
      end
    join
    checkOutput("frame_first", {22'd0, bits1[9:0]}, {22'd0, frame_of(rb)});
    run_device(11, 1'b1, h, bits2);
    checkOutput("frame_F4", {22'd0, bits2[9:0]}, {22'd0, frame_of(8'hF4)});
    wait_idle("F4_idle");

    rb = 8'($urandom);
    h = $urandom_range(30, 45);
    applyStimulus(rb, 1'b0);
    run_device(4, 1'b1, h, bits1);
    checkOutput("frame_pre_reset", {28'd0, bits1[3:0]}, {28'd0, frame_of(rb)} & 32'hF);
    repeat (h) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    checkOutput("reset_status", reg_dat_do, 32'd0);
    repeat (h) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (50) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom);
      full_transfer(rb, 1'($urandom_range(0, 1)), "frame_rand");
    end

    rb = 8'($urandom);
    h = $urandom_range(30, 45);
    applyStimulus(rb, 1'b0);
    run_device(4, 1'b1, h, bits1);
`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n = 0;
      while (tx_busy && n < 26000) begin
        @(negedge clk);
        n++;
      end
      checkOutput("timeout_busy", {31'd0, tx_busy}, 32'd0);
      checkOutput("timeout_status", reg_dat_do, 32'd4);
      checkOutput("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    end
`else
    repeat (25000) @(negedge clk);
    checkOutput("stuck_busy", {31'd0, tx_busy}, 32'd1);
    checkOutput("stuck_status", reg_dat_do, 32'd1);
`endif
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("final_status", reg_dat_do, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
